// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared PC-write encodings, flag bit indices and PC source constants
package cpu_pkg;

    localparam logic [2:0] PCW_NONE = 3'b000;
    localparam logic [2:0] PCW_EQ   = 3'b001;
    localparam logic [2:0] PCW_NE   = 3'b010;
    localparam logic [2:0] PCW_CS   = 3'b011;
    localparam logic [2:0] PCW_CC   = 3'b100;
    localparam logic [2:0] PCW_AL   = 3'b101;
    localparam logic [2:0] PCW_MI   = 3'b110;
    localparam logic [2:0] PCW_PL   = 3'b111;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    localparam logic PCSEL_RESULT = 1'b0;
    localparam logic PCSEL_INC    = 1'b1;

endpackage

// File: rtl/pc_flag_unit_if.sv
// rtl/pc_flag_unit_if.sv - controller strobes into, and PC/LR/flag state out of, the PC/flag unit
interface pc_flag_unit_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic            sclr;
    logic [2:0]      pc_write;
    logic            pc_sel;
    logic            lr_write;
    logic            flag_up;
    logic [3:0]      alu_flags;
    logic [PC_W-1:0] result;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] lr;
    logic [3:0]      flags;
    logic            branch_taken;

    modport master (
        output run, sclr, pc_write, pc_sel, lr_write, flag_up, alu_flags, result,
        input  pc, lr, flags, branch_taken
    );

    modport slave (
        input  run, sclr, pc_write, pc_sel, lr_write, flag_up, alu_flags, result,
        output pc, lr, flags, branch_taken
    );
endinterface

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch-condition evaluation of a PC-write code against NZCV
module cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] pc_write,
    input  logic [3:0] flags,
    output logic       cond
);
    always_comb begin
        cond = 1'b0;
        case (pc_write)
            PCW_NONE: cond = 1'b0;
            PCW_EQ:   cond = flags[FLG_Z];
            PCW_NE:   cond = ~flags[FLG_Z];
            PCW_CS:   cond = flags[FLG_C];
            PCW_CC:   cond = ~flags[FLG_C];
            PCW_AL:   cond = 1'b1;
            PCW_MI:   cond = flags[FLG_N];
            PCW_PL:   cond = ~flags[FLG_N];
            default:  cond = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_flag_unit.sv
// rtl/pc_flag_unit.sv - PC, link register and NZCV flag registers with conditional PC update
module pc_flag_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_flag_unit_if.slave  bus
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] lr_q;
    logic [3:0]      flags_q;
    logic            branch_taken_q;
    logic            cond;
    logic            take;
    logic [PC_W-1:0] pc_next;

    // Condition is tested on the registered flags, so a same-cycle flag_up affects only later branches.
    cond_eval u_cond_eval (
        .pc_write (bus.pc_write),
        .flags    (flags_q),
        .cond     (cond)
    );

    assign take = bus.run & cond;

    always_comb begin
        pc_next = pc_q;
        if (take) begin
            pc_next = (bus.pc_sel == PCSEL_INC) ? pc_q + 1'b1 : bus.result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            lr_q           <= '0;
            flags_q        <= '0;
            branch_taken_q <= 1'b0;
        end else if (bus.sclr) begin
            pc_q           <= RESET_PC;
            lr_q           <= '0;
            flags_q        <= '0;
            branch_taken_q <= 1'b0;
        end else if (bus.run) begin
            pc_q           <= pc_next;
            branch_taken_q <= take & (bus.pc_sel == PCSEL_RESULT);
            if (bus.lr_write) begin
                lr_q <= pc_q;
            end
            if (bus.flag_up) begin
                flags_q <= bus.alu_flags;
            end
        end
    end

    assign bus.pc           = pc_q;
    assign bus.lr           = lr_q;
    assign bus.flags        = flags_q;
    assign bus.branch_taken = branch_taken_q;
endmodule

// File: tb/tb_pc_flag_unit.sv
// tb/tb_pc_flag_unit.sv - scoreboard bench for pc_flag_unit against a behavioural model
module tb_pc_flag_unit;
    localparam int PC_W   = 8;
    localparam int PC_MOD = 1 << PC_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pc_flag_unit_if #(.PC_W(PC_W)) bus ();

    pc_flag_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int    pc;
        int    lr;
        int    flags;
        int    bt;
        string tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_pc   = 0;
    int   m_lr   = 0;
    int   m_flags = 0;
    int   m_bt   = 0;

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    function automatic bit cond_ok(input int code, input int f);
        int n, z, c;
        n = (f >> 3) & 1;
        z = (f >> 2) & 1;
        c = (f >> 1) & 1;
        case (code)
            0: return 1'b0;
            1: return z == 1;
            2: return z == 0;
            3: return c == 1;
            4: return c == 0;
            5: return 1'b1;
            6: return n == 1;
            default: return n == 0;
        endcase
    endfunction

    task automatic step(input string tag, input bit run, input bit sclr, input int pw,
                        input bit sel, input bit lrw, input bit fu, input int af, input int res);
        bit take;
        int npc;
        @(negedge clk);
        bus.run       = run;
        bus.sclr      = sclr;
        bus.pc_write  = pw[2:0];
        bus.pc_sel    = sel;
        bus.lr_write  = lrw;
        bus.flag_up   = fu;
        bus.alu_flags = af[3:0];
        bus.result    = PC_W'(res);
        if (sclr) begin
            m_pc = 0; m_lr = 0; m_flags = 0; m_bt = 0;
        end else if (run) begin
            take = cond_ok(pw, m_flags);
            npc  = take ? (sel ? (m_pc + 1) % PC_MOD : res % PC_MOD) : m_pc;
            if (lrw) m_lr = m_pc;
            if (fu) m_flags = af;
            m_pc = npc;
            m_bt = (take && !sel) ? 1 : 0;
        end
        q.push_back('{m_pc, m_lr, m_flags, m_bt, tag});
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, ".pc"},    int'(bus.pc), 0);
        check({tag, ".lr"},    int'(bus.lr), 0);
        check({tag, ".flags"}, int'(bus.flags), 0);
        check({tag, ".bt"},    int'(bus.branch_taken), 0);
    endtask

    // Asynchronous reset between edges: outputs must clear before any clock edge arrives.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_now(tag);
        m_pc = 0; m_lr = 0; m_flags = 0; m_bt = 0;
        #1 rst_n = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.tag, ".pc"},    int'(bus.pc), e.pc);
                check({e.tag, ".lr"},    int'(bus.lr), e.lr);
                check({e.tag, ".flags"}, int'(bus.flags), e.flags);
                check({e.tag, ".bt"},    int'(bus.branch_taken), e.bt);
            end
        end
    end

    initial begin : stim
        int budget;
        bus.run = 1'b0; bus.sclr = 1'b0; bus.pc_write = 3'b000; bus.pc_sel = 1'b0;
        bus.lr_write = 1'b0; bus.flag_up = 1'b0; bus.alu_flags = 4'h0; bus.result = '0;
        #1 rst_n = 1'b0;
        #1 check_reset_now("reset");
        #2 rst_n = 1'b1;

        step("inc1", 1, 0, 5, 1, 0, 0, 0, 0);
        step("inc2", 1, 0, 5, 1, 0, 0, 0, 0);
        step("inc3", 1, 0, 5, 1, 0, 0, 0, 0);
        step("ld_ff", 1, 0, 5, 0, 0, 0, 0, 'hFF);
        step("wrap", 1, 0, 5, 1, 0, 0, 0, 0);
        step("setz", 1, 0, 0, 0, 0, 1, 4, 0);
        step("beq", 1, 0, 1, 0, 0, 0, 0, 'h20);
        step("idle", 1, 0, 0, 0, 0, 0, 0, 0);
        step("bne", 1, 0, 2, 0, 0, 0, 0, 'h33);
        step("clrf", 1, 0, 0, 0, 0, 1, 0, 0);
        step("same_cyc", 1, 0, 1, 0, 0, 1, 4, 'h50);
        step("ld5", 1, 0, 5, 0, 0, 0, 0, 'h05);
        step("bl", 1, 0, 5, 0, 1, 0, 0, 'h40);
        step("frozen", 0, 0, 5, 1, 1, 1, 'hF, 'h99);
        step("sclr", 0, 1, 5, 1, 1, 1, 'hF, 'h12);
        step("dirty", 1, 0, 5, 0, 1, 1, 'hA, 'h77);
        pulse_reset("async_rst");
        step("post_rst", 1, 0, 5, 1, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 31) == 0,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, PC_MOD - 1)));
        end

        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2 check("drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
